mem_lsu: RTL and testbench

//  Load/store unit at the MEM stage. Consumes the decoded memory controls (mtype, rw, width, rdtype)

---
 rtl/mem_lsu.sv | 167 ++++++++++++++++
 tb/tb_mem_lsu.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: runs req/gnt/rvalid transactions, aligns stores, formats loads.
// Optional bus watchdog enabled by defining LSU_TIMEOUT_EN (TIMEOUT_CYC cycles per bus phase).
module mem_lsu #(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid_i,
   input  logic        ex_mtype_i,
   input  logic        ex_mem_rw_i,
   input  logic [1:0]  ex_mem_width_i,
   input  logic        ex_mem_rdtype_i,
   input  logic [31:0] ex_addr_i,
   input  logic [31:0] ex_wdata_i,
   output logic        dm_req_o,
   output logic        dm_we_o,
   output logic [31:0] dm_addr_o,
   output logic [3:0]  dm_be_o,
   output logic [31:0] dm_wdata_o,
   input  logic        dm_gnt_i,
   input  logic        dm_rvalid_i,
   input  logic [31:0] dm_rdata_i,
   output logic [31:0] lsu_rdata_o,
   output logic        lsu_valid_o,
   output logic        lsu_stall_o,
   output logic        lsu_misalign_o,
   output logic        lsu_bus_err_o
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

   state_t      state, state_nxt;
   logic        is_mem, misaligned, accept, timeout;
   logic [3:0]  be_nxt;
   logic [31:0] wdata_nxt;

   logic        cmd_we, cmd_rdtype;
   logic [1:0]  cmd_width, cmd_off;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic [3:0]  be_q;
   logic        misalign_q;

   // Extracts the addressed lane and sign/zero-extends it according to width.
   function automatic logic [31:0] fmt_load(input logic [31:0] rd, input logic [1:0] off,
                                            input logic [1:0] w, input logic zx);
      logic [31:0] lane;
      lane = rd >> {off, 3'b000};
      case (w)
         2'd0:    fmt_load = zx ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
         2'd1:    fmt_load = zx ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
         default: fmt_load = rd;
      endcase
   endfunction

   // Decodes alignment, byte enables and replicated store data for the incoming command.
   always_comb begin
      is_mem     = ex_valid_i & ex_mtype_i;
      misaligned = 1'b0;
      be_nxt     = 4'b1111;
      wdata_nxt  = ex_wdata_i;
      case (ex_mem_width_i)
         2'd0: begin
            be_nxt    = 4'b0001 << ex_addr_i[1:0];
            wdata_nxt = {4{ex_wdata_i[7:0]}};
         end
         2'd1: begin
            misaligned = ex_addr_i[0];
            be_nxt     = 4'b0011 << ex_addr_i[1:0];
            wdata_nxt  = {2{ex_wdata_i[15:0]}};
         end
         default: misaligned = |ex_addr_i[1:0];
      endcase
      accept = (state == IDLE) & is_mem & ~misaligned;
   end

`ifdef LSU_TIMEOUT_EN
   localparam int CW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
   logic [CW-1:0] tmo_cnt;
   logic          bus_err_q;

   // Counter restarts at the start of each bus phase (request and read-data wait).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt   <= '0;
         bus_err_q <= 1'b0;
      end else begin
         bus_err_q <= timeout;
         if (accept || (state == REQ && dm_gnt_i && !cmd_we))
            tmo_cnt <= '0;
         else if (state == REQ || state == WAIT_R)
            tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   assign timeout = ((state == REQ && !dm_gnt_i) || (state == WAIT_R && !dm_rvalid_i)) &&
                    (tmo_cnt == CW'(TIMEOUT_CYC - 1));
   assign lsu_bus_err_o = bus_err_q;
`else
   assign timeout       = 1'b0;
   assign lsu_bus_err_o = 1'b0;
`endif

   // State register with asynchronous abort to IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic following the bus handshake phases.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   if (accept) state_nxt = REQ;
         REQ: begin
            if (timeout)       state_nxt = IDLE;
            else if (dm_gnt_i) state_nxt = cmd_we ? DONE : WAIT_R;
         end
         WAIT_R: begin
            if (timeout)          state_nxt = IDLE;
            else if (dm_rvalid_i) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Command is latched at accept so upstream can drop it; the load result is
   // written when entering DONE and then held until the next completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_we     <= 1'b0;
         cmd_rdtype <= 1'b0;
         cmd_width  <= 2'd0;
         cmd_off    <= 2'd0;
         addr_q     <= '0;
         be_q       <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= (state == IDLE) & is_mem & misaligned;
         if (accept) begin
            cmd_we     <= ~ex_mem_rw_i;
            cmd_rdtype <= ex_mem_rdtype_i;
            cmd_width  <= ex_mem_width_i;
            cmd_off    <= ex_addr_i[1:0];
            addr_q     <= {ex_addr_i[31:2], 2'b00};
            be_q       <= be_nxt;
            wdata_q    <= wdata_nxt;
         end
         if (state == REQ && dm_gnt_i && cmd_we && !timeout)
            rdata_q <= '0;
         else if (state == WAIT_R && dm_rvalid_i)
            rdata_q <= fmt_load(dm_rdata_i, cmd_off, cmd_width, cmd_rdtype);
      end
   end

   assign dm_req_o       = (state == REQ);
   assign dm_we_o        = cmd_we;
   assign dm_addr_o      = addr_q;
   assign dm_be_o        = be_q;
   assign dm_wdata_o     = wdata_q;
   assign lsu_rdata_o    = rdata_q;
   assign lsu_valid_o    = (state == DONE);
   assign lsu_stall_o    = accept | (state == REQ) | (state == WAIT_R);
   assign lsu_misalign_o = misalign_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu; the watchdog case runs only with LSU_TIMEOUT_EN.
module tb_mem_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_mtype, ex_rw, ex_rdtype;
   logic [1:0]  ex_width;
   logic [31:0] ex_addr, ex_wdata;
   logic        dm_req, dm_we, dm_gnt, dm_rvalid;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic [3:0]  dm_be;
   logic [31:0] lsu_rdata;
   logic        lsu_valid, lsu_stall, lsu_misalign, lsu_bus_err;

   int assert_count = 0;
   int fail_count   = 0;

   // Free-running clock, 10 time-unit period.
   always #5 clk = ~clk;

   mem_lsu #(.TIMEOUT_CYC(8)) dut (
      .clk(clk), .rst(rst),
      .ex_valid_i(ex_valid), .ex_mtype_i(ex_mtype), .ex_mem_rw_i(ex_rw),
      .ex_mem_width_i(ex_width), .ex_mem_rdtype_i(ex_rdtype),
      .ex_addr_i(ex_addr), .ex_wdata_i(ex_wdata),
      .dm_req_o(dm_req), .dm_we_o(dm_we), .dm_addr_o(dm_addr), .dm_be_o(dm_be),
      .dm_wdata_o(dm_wdata), .dm_gnt_i(dm_gnt), .dm_rvalid_i(dm_rvalid), .dm_rdata_i(dm_rdata),
      .lsu_rdata_o(lsu_rdata), .lsu_valid_o(lsu_valid), .lsu_stall_o(lsu_stall),
      .lsu_misalign_o(lsu_misalign), .lsu_bus_err_o(lsu_bus_err)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assert_count++;
      if (obs !== exp) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic mtype, input logic rw,
                                input logic [1:0] width, input logic rdtype,
                                input logic [31:0] addr, input logic [31:0] wdata);
      ex_valid  = valid;
      ex_mtype  = mtype;
      ex_rw     = rw;
      ex_width  = width;
      ex_rdtype = rdtype;
      ex_addr   = addr;
      ex_wdata  = wdata;
   endtask

   // Load with immediate grant and read data the cycle after the grant.
   task automatic runLoad(input string tag, input logic [31:0] addr, input logic [1:0] width,
                          input logic rdtype, input logic [31:0] rdata,
                          input logic [3:0] exp_be, input logic [31:0] exp_res);
      @(negedge clk);
      applyStimulus(1, 1, 1, width, rdtype, addr, 32'h0);
      dm_gnt = 1'b1;
      #1 checkOutput({tag, "_stall_accept"}, lsu_stall, 1);
      @(negedge clk);
      applyStimulus(0, 0, 0, 2'd0, 0, 32'h0, 32'h0);
      checkOutput({tag, "_req"}, dm_req, 1);
      checkOutput({tag, "_we"}, dm_we, 0);
      checkOutput({tag, "_addr"}, dm_addr, {addr[31:2], 2'b00});
      checkOutput({tag, "_be"}, dm_be, exp_be);
      @(negedge clk);
      dm_gnt    = 1'b0;
      dm_rvalid = 1'b1;
      dm_rdata  = rdata;
      checkOutput({tag, "_wait_stall"}, lsu_stall, 1);
      checkOutput({tag, "_wait_valid"}, lsu_valid, 0);
      @(negedge clk);
      dm_rvalid = 1'b0;
      dm_rdata  = 32'h0;
      checkOutput({tag, "_done_valid"}, lsu_valid, 1);
      checkOutput({tag, "_done_stall"}, lsu_stall, 0);
      checkOutput({tag, "_rdata"}, lsu_rdata, exp_res);
      @(negedge clk);
      checkOutput({tag, "_valid_drop"}, lsu_valid, 0);
      checkOutput({tag, "_rdata_hold"}, lsu_rdata, exp_res);
   endtask

   // Global simulation time limit.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] time limit");
   end

   // Main directed test sequence.
   initial begin
      int valid_seen;
      rst = 1'b1;
      dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'h0;
      applyStimulus(0, 0, 0, 2'd0, 0, 32'h0, 32'h0);
      @(negedge clk);
      checkOutput("rst_req", dm_req, 0);
      checkOutput("rst_valid", lsu_valid, 0);
      checkOutput("rst_stall", lsu_stall, 0);
      checkOutput("rst_rdata", lsu_rdata, 0);
      checkOutput("rst_addr", dm_addr, 0);
      checkOutput("rst_misalign", lsu_misalign, 0);
      checkOutput("rst_bus_err", lsu_bus_err, 0);
      rst = 1'b0;

      $display("[TB] store byte with immediate grant");
      @(negedge clk);
      applyStimulus(1, 1, 0, 2'd0, 0, 32'h0000_1002, 32'hAABB_CCDD);
      dm_gnt = 1'b1;
      #1 checkOutput("sb_stall_accept", lsu_stall, 1);
      checkOutput("sb_no_req_accept", dm_req, 0);
      @(negedge clk);
      applyStimulus(0, 0, 0, 2'd0, 0, 32'h0, 32'h0);
      checkOutput("sb_req", dm_req, 1);
      checkOutput("sb_we", dm_we, 1);
      checkOutput("sb_addr", dm_addr, 32'h0000_1000);
      checkOutput("sb_be", dm_be, 4'b0100);
      checkOutput("sb_wdata", dm_wdata, 32'hDDDD_DDDD);
      checkOutput("sb_valid_early", lsu_valid, 0);
      @(negedge clk);
      dm_gnt = 1'b0;
      checkOutput("sb_valid", lsu_valid, 1);
      checkOutput("sb_stall_done", lsu_stall, 0);
      checkOutput("sb_rdata_zero", lsu_rdata, 0);
      checkOutput("sb_req_drop", dm_req, 0);
      @(negedge clk);
      checkOutput("sb_valid_drop", lsu_valid, 0);

      $display("[TB] store half / word lane replication");
      @(negedge clk);
      applyStimulus(1, 1, 0, 2'd1, 0, 32'h0000_0106, 32'h1234_5678);
      dm_gnt = 1'b1;
      @(negedge clk);
      applyStimulus(0, 0, 0, 2'd0, 0, 32'h0, 32'h0);
      checkOutput("sh_be", dm_be, 4'b1100);
      checkOutput("sh_wdata", dm_wdata, 32'h5678_5678);
      checkOutput("sh_addr", dm_addr, 32'h0000_0104);
      @(negedge clk);
      dm_gnt = 1'b0;
      checkOutput("sh_valid", lsu_valid, 1);

      runLoad("lh",  32'h0000_2002, 2'd1, 0, 32'h8001_1234, 4'b1100, 32'hFFFF_8001);
      runLoad("lhu", 32'h0000_2002, 2'd1, 1, 32'h8001_1234, 4'b1100, 32'h0000_8001);
      runLoad("lb",  32'h0000_0013, 2'd0, 0, 32'h7F80_0000, 4'b1000, 32'h0000_007F);
      runLoad("lb_neg", 32'h0000_0011, 2'd0, 0, 32'h0000_8000, 4'b0010, 32'hFFFF_FF80);
      runLoad("lbu", 32'h0000_0011, 2'd0, 1, 32'h0000_8000, 4'b0010, 32'h0000_0080);
      runLoad("lw3", 32'h0000_0040, 2'd3, 0, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);

      $display("[TB] misaligned word load");
      @(negedge clk);
      applyStimulus(1, 1, 1, 2'd2, 0, 32'h0000_3001, 32'h0);
      dm_gnt = 1'b1;
      #1 checkOutput("mis_stall", lsu_stall, 0);
      @(negedge clk);
      applyStimulus(0, 0, 0, 2'd0, 0, 32'h0, 32'h0);
      checkOutput("mis_pulse", lsu_misalign, 1);
      checkOutput("mis_req", dm_req, 0);
      checkOutput("mis_valid", lsu_valid, 0);
      @(negedge clk);
      dm_gnt = 1'b0;
      checkOutput("mis_pulse_drop", lsu_misalign, 0);
      checkOutput("mis_req2", dm_req, 0);
      checkOutput("mis_valid2", lsu_valid, 0);

      $display("[TB] non-memory instruction");
      @(negedge clk);
      applyStimulus(1, 0, 1, 2'd2, 0, 32'h0000_3001, 32'h0);
      #1 checkOutput("nonmem_stall", lsu_stall, 0);
      @(negedge clk);
      applyStimulus(0, 0, 0, 2'd0, 0, 32'h0, 32'h0);
      checkOutput("nonmem_req", dm_req, 0);
      checkOutput("nonmem_misalign", lsu_misalign, 0);
      checkOutput("nonmem_valid", lsu_valid, 0);

      $display("[TB] load with grant delayed five cycles");
      @(negedge clk);
      applyStimulus(1, 1, 1, 2'd2, 0, 32'h0000_4000, 32'h0);
      dm_gnt = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 0) applyStimulus(0, 0, 0, 2'd0, 0, 32'h0, 32'h0);
         dm_rvalid = (i == 1);
         dm_rdata  = 32'hBAD0_BAD0;
         dm_gnt    = (i == 4);
         checkOutput("dly_req", dm_req, 1);
         checkOutput("dly_addr", dm_addr, 32'h0000_4000);
         checkOutput("dly_stall", lsu_stall, 1);
      end
      @(negedge clk);
      dm_gnt    = 1'b0;
      dm_rvalid = 1'b1;
      dm_rdata  = 32'h1234_5678;
      checkOutput("dly_wait_req", dm_req, 0);
      checkOutput("dly_wait_stall", lsu_stall, 1);
      valid_seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         dm_rvalid = 1'b0;
         if (lsu_valid) valid_seen++;
      end
      checkOutput("dly_valid_count", valid_seen, 1);
      checkOutput("dly_rdata", lsu_rdata, 32'h1234_5678);

      $display("[TB] reset while requesting");
      @(negedge clk);
      applyStimulus(1, 1, 1, 2'd2, 0, 32'h0000_6000, 32'h0);
      @(negedge clk);
      applyStimulus(0, 0, 0, 2'd0, 0, 32'h0, 32'h0);
      checkOutput("rreq_req", dm_req, 1);
      #2 rst = 1'b1;
      #1 checkOutput("rreq_req_drop", dm_req, 0);
      checkOutput("rreq_stall_drop", lsu_stall, 0);
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] reset while waiting for read data");
      @(negedge clk);
      applyStimulus(1, 1, 1, 2'd2, 0, 32'h0000_5000, 32'h0);
      dm_gnt = 1'b1;
      @(negedge clk);
      applyStimulus(0, 0, 0, 2'd0, 0, 32'h0, 32'h0);
      @(negedge clk);
      dm_gnt = 1'b0;
      checkOutput("rw_stall_before", lsu_stall, 1);
      #2 rst = 1'b1;
      #1 checkOutput("rw_stall_drop", lsu_stall, 0);
      checkOutput("rw_req_drop", dm_req, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      dm_rvalid = 1'b1;
      dm_rdata  = 32'hFFFF_FFFF;
      @(negedge clk);
      dm_rvalid = 1'b0;
      checkOutput("rw_late_valid", lsu_valid, 0);
      checkOutput("rw_late_stall", lsu_stall, 0);
      @(negedge clk);
      checkOutput("rw_late_valid2", lsu_valid, 0);
      checkOutput("rw_rdata_cleared", lsu_rdata, 0);
      runLoad("lbu_after_rst", 32'h0000_5003, 2'd0, 1, 32'hAB00_0000, 4'b1000, 32'h0000_00AB);

`ifdef LSU_TIMEOUT_EN
      $display("[TB] bus watchdog with grant never given");
      @(negedge clk);
      applyStimulus(1, 1, 1, 2'd2, 0, 32'h0000_7000, 32'h0);
      dm_gnt = 1'b0;
      valid_seen = 0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (i == 1) applyStimulus(0, 0, 0, 2'd0, 0, 32'h0, 32'h0);
         if (lsu_valid) valid_seen++;
         if (i <= 8) checkOutput("tmo_req_held", dm_req, 1);
         if (i == 9) begin
            checkOutput("tmo_bus_err", lsu_bus_err, 1);
            checkOutput("tmo_req_drop", dm_req, 0);
            checkOutput("tmo_stall_drop", lsu_stall, 0);
         end else begin
            checkOutput("tmo_bus_err_quiet", lsu_bus_err, 0);
         end
      end
      checkOutput("tmo_no_valid", valid_seen, 0);
      runLoad("lw_after_tmo", 32'h0000_7004, 2'd2, 0, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D);
`endif

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
